// File: rtl/alu_slice_sequencer.sv
// ============================================================================
// alu_slice_sequencer: runs a 16-bit AND/OR/XOR/NOR/ADD as four 4-bit slices
// through an external 4-bit ALU, rippling carry between slices for ADD.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_slice_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  input  logic [3:0]  alu_result,
  input  logic        alu_cout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  op_q;
  logic        carry_q;
  logic [15:0] acc;
  logic [3:0]  base;
  logic        is_add;
  logic        accept;

  assign base   = {idx, 2'b00};
  assign is_add = op_q[2];
  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    if (rsp_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // ALU drive is forced quiet outside RUN so the external ALU sees no stale slices.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    alu_op    = 3'd0;
    alu_cin   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        busy      = 1'b0;
      end
      RUN: begin
        alu_a   = a_q[base +: 4];
        alu_b   = b_q[base +: 4];
        alu_op  = op_q;
        alu_cin = is_add & carry_q;
      end
      DONE: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      op_q       <= 3'd0;
      carry_q    <= 1'b0;
      acc        <= 16'd0;
      rsp_result <= 16'd0;
      rsp_carry  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= req_a;
            b_q     <= req_b;
            op_q    <= req_op;
            idx     <= 2'd0;
            carry_q <= 1'b0;
          end
        end
        RUN: begin
          acc[base +: 4] <= alu_result;
          if (is_add) begin
            carry_q <= alu_cout;
          end
          idx <= idx + 2'd1;
          // Response registers update only on the final slice so they hold outside DONE.
          if (idx == 2'd3) begin
            rsp_result <= {alu_result, acc[11:0]};
            rsp_carry  <= is_add & alu_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_slice_sequencer.sv
// ============================================================================
// tb_alu_slice_sequencer: directed self-checking bench with a behavioural 4-bit ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_slice_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [3:0]  alu_result;
  logic        alu_cout;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_slice_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; logic ops report cout=1 so a leak into rsp_carry is visible.
  always_comb begin
    alu_result = 4'd0;
    alu_cout   = 1'b1;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: alu_result = ~(alu_a | alu_b);
      default: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the block back in IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [15:0] exp_res,
                        input logic exp_c, input int hold, input logic [3:0] exp_cin,
                        input logic chk_cin);
    int k;
    logic [3:0] cin_seen;
    cin_seen  = 4'd0;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = 16'h1357;
    req_op    = 3'b011;
    k = 1;
    while (!rsp_valid && k < 12) begin
      if (k <= 4) cin_seen[k-1] = alu_cin;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'd5);
    if (chk_cin) check({tag, "_cin"}, 32'(cin_seen), 32'(exp_cin));
    check({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_c"}, 32'(rsp_carry), 32'(exp_c));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_r"}, 32'(rsp_result), 32'(exp_res));
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_post_v"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_rdy"}, 32'(req_ready), 32'd1);
    check({tag, "_post_keep"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_post_alu"}, 32'({alu_a, alu_b, alu_op, alu_cin}), 32'd0);
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    req_op    = 3'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_res", 32'({rsp_carry, rsp_result}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 32'(req_ready), 32'd1);

    run_op("add_ff", 16'h00FF, 16'h0001, 3'b100, 16'h0100, 1'b0, 0, 4'b0000, 1'b0);
    run_op("add_ffff", 16'hFFFF, 16'h0001, 3'b100, 16'h0000, 1'b1, 0, 4'b1110, 1'b1);
    run_op("and", 16'hF0F0, 16'h0FF0, 3'b000, 16'h00F0, 1'b0, 0, 4'b0000, 1'b1);
    run_op("nor", 16'h0000, 16'h0000, 3'b011, 16'hFFFF, 1'b0, 0, 4'b0000, 1'b1);
    run_op("xor", 16'hAAAA, 16'hFFFF, 3'b010, 16'h5555, 1'b0, 3, 4'b0000, 1'b1);
    run_op("or", 16'h1234, 16'h8421, 3'b001, 16'h9635, 1'b0, 0, 4'b0000, 1'b0);
    run_op("add_msb", 16'h8000, 16'h8000, 3'b110, 16'h0000, 1'b1, 0, 4'b0000, 1'b1);
    run_op("add_111", 16'h1234, 16'h0FFF, 3'b111, 16'h2233, 1'b0, 0, 4'b1110, 1'b1);

    // Reset while idx=2 discards the operation.
    req_a = 16'hFFFF; req_b = 16'hFFFF; req_op = 3'b100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rrun_busy", 32'(busy), 32'd0);
    check("rrun_ready", 32'(req_ready), 32'd0);
    check("rrun_res", 32'({rsp_carry, rsp_result}), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rrun_novalid", 32'(seen), 32'd0);
    run_op("add_1_1", 16'h0001, 16'h0001, 3'b100, 16'h0002, 1'b0, 0, 4'b0000, 1'b1);

    // Back-to-back with req_valid held high; second accept only after the handshake.
    req_a = 16'h0F0F; req_b = 16'h0101; req_op = 3'b100; req_valid = 1'b1;
    @(negedge clk);
    req_a = 16'h3333; req_b = 16'h5555; req_op = 3'b010;
    seen = 0;
    while (!rsp_valid && seen < 12) begin
      @(negedge clk);
      seen++;
    end
    check("b2b_first_res", 32'({rsp_carry, rsp_result}), 32'h01010);
    check("b2b_done_rdy", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_idle_rdy", 32'(req_ready), 32'd1);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    seen = 0;
    while (!rsp_valid && seen < 12) begin
      @(negedge clk);
      seen++;
    end
    check("b2b_second_res", 32'({rsp_carry, rsp_result}), 32'h06666);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
